// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port, fixed-latency unified memory.
// Data port has priority; a streak counter lets a waiting instruction fetch in.
module mem_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int MEM_LATENCY = 2,
  parameter int STREAK_MAX  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_readM,
  input  logic                 i_writeM,
  input  logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_wdata,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_ready,
  input  logic                 d_readM,
  input  logic                 d_writeM,
  input  logic [WORD_SIZE-1:0] d_address,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ready,
  output logic                 m_read,
  output logic                 m_write,
  output logic [WORD_SIZE-1:0] m_address,
  output logic [WORD_SIZE-1:0] m_wdata,
  input  logic [WORD_SIZE-1:0] m_rdata,
  output logic                 i_grant,
  output logic                 d_grant,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  // Request/ready handshake: a port requests by holding readM and/or writeM
  // high (both high means write); the request is latched in IDLE, and the
  // port's ready pulses for one cycle in RESP with rdata already valid. The
  // requester drops or replaces its request at the edge that ends that cycle.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] SMAX   = 4'(STREAK_MAX);

  state_t state, state_next;
  logic [3:0] counter, counter_next;
  logic [3:0] streak, streak_next;
  logic       owner_d;
  logic       op_write;
  logic [WORD_SIZE-1:0] addr_q, wdata_q, i_rdata_q, d_rdata_q;
  logic       i_pend, d_pend;
  logic       grant_valid, grant_d, capture;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    i_pend       = i_readM | i_writeM;
    d_pend       = d_readM | d_writeM;
    state_next   = state;
    counter_next = counter;
    streak_next  = streak;
    grant_valid  = 1'b0;
    grant_d      = 1'b0;
    capture      = 1'b0;
    case (state)
      IDLE: begin
        if (i_pend || d_pend) begin
          grant_valid  = 1'b1;
          // A full streak hands the next slot to a waiting instruction fetch.
          grant_d      = d_pend && !(i_pend && (streak == SMAX));
          counter_next = LAT_M1;
          state_next   = ACCESS;
          if (!grant_d)    streak_next = 4'd0;
          else if (i_pend) streak_next = (streak == SMAX) ? streak : streak + 4'd1;
          else             streak_next = 4'd0;
        end
      end
      ACCESS: begin
        if (counter == 4'd0) begin
          capture      = !op_write;
          counter_next = 4'd0;
          state_next   = RESP;
        end else begin
          counter_next = counter - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter   <= 4'd0;
      streak    <= 4'd0;
      owner_d   <= 1'b0;
      op_write  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      counter <= counter_next;
      streak  <= streak_next;
      if (grant_valid) begin
        owner_d  <= grant_d;
        op_write <= grant_d ? d_writeM  : i_writeM;
        addr_q   <= grant_d ? d_address : i_address;
        wdata_q  <= grant_d ? d_wdata   : i_wdata;
      end
      if (capture) begin
        if (owner_d) d_rdata_q <= m_rdata;
        else         i_rdata_q <= m_rdata;
      end
    end
  end

  always_comb begin
    m_read    = (state == ACCESS) && !op_write;
    m_write   = (state == ACCESS) && op_write;
    busy      = (state == ACCESS) || (state == RESP);
    i_grant   = busy && !owner_d;
    d_grant   = busy && owner_d;
    i_ready   = (state == RESP) && !owner_d;
    d_ready   = (state == RESP) && owner_d;
    m_address = addr_q;
    m_wdata   = wdata_q;
    i_rdata   = i_rdata_q;
    d_rdata   = d_rdata_q;
    state_dbg = state;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized two-port traffic
// checked against a transaction-level timing model.
module tb_mem_arbiter;
  localparam int W    = 16;
  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_readM, i_writeM, d_readM, d_writeM;
  logic [W-1:0] i_address, i_wdata, d_address, d_wdata;
  logic [W-1:0] i_rdata, d_rdata, m_address, m_wdata, m_rdata;
  logic i_ready, d_ready, m_read, m_write, i_grant, d_grant, busy;
  logic [1:0] state_dbg;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(LAT), .STREAK_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .i_readM(i_readM), .i_writeM(i_writeM), .i_address(i_address), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .i_grant(i_grant), .d_grant(d_grant), .busy(busy),
    .state_dbg(state_dbg)
  );

  // Memory environment: unwritten words read back a fixed hash of the address.
  logic [W-1:0] mem [4096];
  bit           mem_wr [4096];
  logic         pl_en = 1'b0;
  logic [W-1:0] pl_addr, pl_data;
  logic [W-1:0] ref_val [4096];
  bit           ref_wr [4096];

  function automatic logic [W-1:0] mem_default(input logic [W-1:0] a);
    logic [W-1:0] r;
    r = (a * 16'h9E37) ^ 16'h5A5A;
    return r;
  endfunction

  always @(posedge clk) begin
    if (m_write) begin
      mem[m_address[11:0]]    <= m_wdata;
      mem_wr[m_address[11:0]] <= 1'b1;
    end else if (pl_en) begin
      mem[pl_addr[11:0]]    <= pl_data;
      mem_wr[pl_addr[11:0]] <= 1'b1;
    end
  end

  assign m_rdata = mem_wr[m_address[11:0]] ? mem[m_address[11:0]] : mem_default(m_address);

  task automatic clear_inputs();
    i_readM = 1'b0; i_writeM = 1'b0; i_address = '0; i_wdata = '0;
    d_readM = 1'b0; d_writeM = 1'b0; d_address = '0; d_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic mem_preload(input logic [W-1:0] a, input logic [W-1:0] v);
    pl_addr = a; pl_data = v; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [4*W+7-1:0] got;
    @(negedge clk);
    reset = 1'b1;
    i_readM = 1'b1; d_writeM = 1'b1; i_address = 16'h1234; d_wdata = 16'hFFFF;
    repeat (2) @(negedge clk);
    got = {i_rdata, d_rdata, m_address, m_wdata, i_ready, d_ready, m_read, m_write, i_grant, d_grant, busy};
    n_vec++;
    if (got !== '0) begin n_err++; $display("FAIL reset_held outputs got %h exp 0", got); end
    clear_inputs();
    reset = 1'b0;
    @(negedge clk);
    got = {i_rdata, d_rdata, m_address, m_wdata, i_ready, d_ready, m_read, m_write, i_grant, d_grant, busy};
    n_vec++;
    if (got !== '0) begin n_err++; $display("FAIL reset_idle outputs got %h exp 0", got); end
  endtask

  task automatic test_instr_read();
    bit e_acc, e_rdy;
    do_reset();
    mem_preload(16'h0010, 16'hABCD);
    i_readM = 1'b1; i_address = 16'h0010;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      e_acc = (c == 1 || c == 2);
      e_rdy = (c == 3);
      n_vec++;
      if (m_read !== e_acc) begin n_err++; $display("FAIL instr_read m_read c=%0d got %b exp %b", c, m_read, e_acc); end
      n_vec++;
      if (i_ready !== e_rdy) begin n_err++; $display("FAIL instr_read i_ready c=%0d got %b exp %b", c, i_ready, e_rdy); end
      n_vec++;
      if (d_ready !== 1'b0) begin n_err++; $display("FAIL instr_read d_ready c=%0d got %b exp 0", c, d_ready); end
      if (e_acc) begin
        n_vec++;
        if (m_address !== 16'h0010) begin n_err++; $display("FAIL instr_read m_address c=%0d got %h exp 0010", c, m_address); end
      end
      if (e_rdy) begin
        n_vec++;
        if (i_rdata !== 16'hABCD) begin n_err++; $display("FAIL instr_read i_rdata got %h exp abcd", i_rdata); end
        i_readM = 1'b0;
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] e_addr;
    bit e_acc;
    do_reset();
    mem_preload(16'h8000, 16'h1357);
    mem_preload(16'h0001, 16'h2468);
    i_readM = 1'b1; i_address = 16'h0001;
    d_readM = 1'b1; d_address = 16'h8000;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      e_acc  = (c == 1 || c == 2 || c == 5 || c == 6);
      e_addr = (c <= 4) ? 16'h8000 : 16'h0001;
      n_vec++;
      if (m_read !== e_acc) begin n_err++; $display("FAIL simult m_read c=%0d got %b exp %b", c, m_read, e_acc); end
      if (e_acc) begin
        n_vec++;
        if (m_address !== e_addr) begin n_err++; $display("FAIL simult m_address c=%0d got %h exp %h", c, m_address, e_addr); end
      end
      n_vec++;
      if ({i_ready, d_ready} !== {c == 7, c == 3}) begin
        n_err++; $display("FAIL simult ready c=%0d got i%b d%b exp i%b d%b", c, i_ready, d_ready, c == 7, c == 3);
      end
      n_vec++;
      if ({i_grant, d_grant} !== {c >= 5 && c <= 7, c >= 1 && c <= 3}) begin
        n_err++; $display("FAIL simult grant c=%0d got i%b d%b", c, i_grant, d_grant);
      end
      if (c == 3) begin
        n_vec++;
        if (d_rdata !== 16'h1357) begin n_err++; $display("FAIL simult d_rdata got %h exp 1357", d_rdata); end
        d_readM = 1'b0;
      end
      if (c == 7) begin
        n_vec++;
        if (i_rdata !== 16'h2468) begin n_err++; $display("FAIL simult i_rdata got %h exp 2468", i_rdata); end
        i_readM = 1'b0;
      end
    end
  endtask

  task automatic test_starvation();
    int k;
    bit e_d;
    do_reset();
    i_readM = 1'b1; i_address = 16'h0002;
    d_readM = 1'b1; d_address = 16'h0100;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      n_vec++;
      if (i_grant && d_grant) begin n_err++; $display("FAIL starve both_grants c=%0d got 11 exp one-hot", c); end
      if (c % 4 == 1) begin
        k   = (c - 1) / 4;
        e_d = (k % (SMAX + 1)) != SMAX;
        n_vec++;
        if ({i_grant, d_grant} !== {!e_d, e_d}) begin
          n_err++; $display("FAIL starve grant_%0d got i%b d%b exp i%b d%b", k, i_grant, d_grant, !e_d, e_d);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_data_write();
    bit e_acc;
    do_reset();
    mem_preload(16'h0300, 16'h5555);
    d_readM = 1'b1; d_address = 16'h0300;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({d_ready, d_rdata} !== {1'b1, 16'h5555}) begin
      n_err++; $display("FAIL wr_preset d_ready/d_rdata got %b/%h exp 1/5555", d_ready, d_rdata);
    end
    d_readM = 1'b0;
    @(negedge clk);
    d_writeM = 1'b1; d_address = 16'h0200; d_wdata = 16'h1234;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      e_acc = (c == 1 || c == 2);
      n_vec++;
      if ({m_write, m_read} !== {e_acc, 1'b0}) begin
        n_err++; $display("FAIL data_write strobes c=%0d got w%b r%b exp w%b r0", c, m_write, m_read, e_acc);
      end
      if (e_acc) begin
        n_vec++;
        if ({m_address, m_wdata} !== {16'h0200, 16'h1234}) begin
          n_err++; $display("FAIL data_write addr/wdata c=%0d got %h/%h exp 0200/1234", c, m_address, m_wdata);
        end
      end
      n_vec++;
      if (d_ready !== (c == 3)) begin n_err++; $display("FAIL data_write d_ready c=%0d got %b exp %b", c, d_ready, c == 3); end
      n_vec++;
      if (d_rdata !== 16'h5555) begin n_err++; $display("FAIL data_write d_rdata c=%0d got %h exp 5555", c, d_rdata); end
      if (c == 3) d_writeM = 1'b0;
    end
    n_vec++;
    if (mem[12'h200] !== 16'h1234) begin n_err++; $display("FAIL data_write mem got %h exp 1234", mem[12'h200]); end
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    mem_preload(16'h0300, 16'h5555);
    d_readM = 1'b1; d_address = 16'h0300;
    @(negedge clk);
    n_vec++;
    if (m_read !== 1'b1) begin n_err++; $display("FAIL rst_mid first_access m_read got %b exp 1", m_read); end
    reset = 1'b1; d_readM = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({m_read, busy, d_grant, d_ready, d_rdata} !== '0) begin
      n_err++; $display("FAIL rst_mid after_reset got r%b b%b g%b rdy%b rd%h exp all 0", m_read, busy, d_grant, d_ready, d_rdata);
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if ({d_ready, busy} !== 2'b00) begin n_err++; $display("FAIL rst_mid quiet c=%0d got rdy%b busy%b exp 00", c, d_ready, busy); end
    end
    d_readM = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({d_ready, d_rdata} !== {1'b1, 16'h5555}) begin
      n_err++; $display("FAIL rst_mid reissue got %b/%h exp 1/5555", d_ready, d_rdata);
    end
    d_readM = 1'b0;
  endtask

  task automatic test_read_write_both();
    int pulses = 0;
    bit e_acc;
    do_reset();
    d_readM = 1'b1; d_writeM = 1'b1; d_address = 16'h0400; d_wdata = 16'h0F0F;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      e_acc = (c == 1 || c == 2);
      n_vec++;
      if ({m_write, m_read} !== {e_acc, 1'b0}) begin
        n_err++; $display("FAIL rw_both strobes c=%0d got w%b r%b exp w%b r0", c, m_write, m_read, e_acc);
      end
      if (d_ready) pulses++;
      if (c == 3) begin d_readM = 1'b0; d_writeM = 1'b0; end
    end
    n_vec++;
    if (pulses != 1) begin n_err++; $display("FAIL rw_both d_ready_pulses got %0d exp 1", pulses); end
    n_vec++;
    if (mem[12'h400] !== 16'h0F0F) begin n_err++; $display("FAIL rw_both mem got %h exp 0f0f", mem[12'h400]); end
  endtask

  task automatic test_random(input int n_cycles);
    bit rq_on[2], rq_r[2], rq_w[2], last_rdy[2];
    logic [W-1:0] rq_a[2], rq_wd[2], e_rd[2];
    bit t_valid, t_wr, in_acc, in_resp, ip, dp;
    int t_port, t_start, free_at, streak_m, win, k, r;
    logic [W-1:0] t_addr, t_wd, t_rd, e_ma, e_mwd;
    logic [6:0] e_ctl, g_ctl;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      rq_on[p] = 0; rq_r[p] = 0; rq_w[p] = 0; last_rdy[p] = 0;
      rq_a[p] = '0; rq_wd[p] = '0; e_rd[p] = '0;
    end
    t_valid = 0; t_wr = 0; t_port = 0; t_start = 0; free_at = 0; streak_m = 0;
    t_addr = '0; t_wd = '0; t_rd = '0; e_ma = '0; e_mwd = '0;
    for (int cyc = 0; cyc < n_cycles; cyc++) begin
      if (cyc > 0) @(negedge clk);
      // requesters: hold until ready, optionally meddle with a request already latched
      for (int p = 0; p < 2; p++) begin
        if (last_rdy[p]) rq_on[p] = 0;
        if (!rq_on[p]) begin
          if ($urandom_range(0, 99) < 40) begin
            k = $urandom_range(0, 3);
            rq_on[p] = 1; rq_r[p] = (k != 1); rq_w[p] = (k == 1 || k == 2);
            rq_a[p]  = {4'($urandom_range(0, 15)), 12'h800 | 12'($urandom_range(0, 31))};
            rq_wd[p] = 16'($urandom);
          end
        end else if (t_valid && t_port == p && cyc > t_start && cyc <= t_start + LAT) begin
          r = $urandom_range(0, 99);
          if (r < 5) rq_on[p] = 0;
          else if (r < 25) begin rq_a[p] = 16'($urandom); rq_wd[p] = 16'($urandom); end
        end
      end
      i_readM = rq_on[0] & rq_r[0]; i_writeM = rq_on[0] & rq_w[0]; i_address = rq_a[0]; i_wdata = rq_wd[0];
      d_readM = rq_on[1] & rq_r[1]; d_writeM = rq_on[1] & rq_w[1]; d_address = rq_a[1]; d_wdata = rq_wd[1];

      in_acc  = t_valid && cyc > t_start && cyc <= t_start + LAT;
      in_resp = t_valid && cyc == t_start + LAT + 1;
      if (in_resp && !t_wr) e_rd[t_port] = t_rd;
      e_ctl = {in_acc && !t_wr, in_acc && t_wr, in_acc || in_resp,
               (in_acc || in_resp) && t_port == 0, (in_acc || in_resp) && t_port == 1,
               in_resp && t_port == 0, in_resp && t_port == 1};
      g_ctl = {m_read, m_write, busy, i_grant, d_grant, i_ready, d_ready};
      n_vec++;
      if (g_ctl !== e_ctl) begin n_err++; $display("FAIL rand ctl cyc=%0d got %b exp %b", cyc, g_ctl, e_ctl); end
      n_vec++;
      if ({m_address, m_wdata} !== {e_ma, e_mwd}) begin
        n_err++; $display("FAIL rand m_addr/wdata cyc=%0d got %h/%h exp %h/%h", cyc, m_address, m_wdata, e_ma, e_mwd);
      end
      n_vec++;
      if ({i_rdata, d_rdata} !== {e_rd[0], e_rd[1]}) begin
        n_err++; $display("FAIL rand rdata cyc=%0d got i%h d%h exp i%h d%h", cyc, i_rdata, d_rdata, e_rd[0], e_rd[1]);
      end

      last_rdy[0] = in_resp && t_port == 0;
      last_rdy[1] = in_resp && t_port == 1;
      if (cyc >= free_at) begin
        ip = rq_on[0];
        dp = rq_on[1];
        if (ip || dp) begin
          win = (dp && !(ip && streak_m == SMAX)) ? 1 : 0;
          if (win == 0)  streak_m = 0;
          else if (ip)   streak_m = (streak_m < SMAX) ? streak_m + 1 : SMAX;
          else           streak_m = 0;
          t_valid = 1; t_port = win; t_start = cyc; free_at = cyc + LAT + 2;
          t_wr = rq_w[win]; t_addr = rq_a[win]; t_wd = rq_wd[win];
          e_ma = t_addr; e_mwd = t_wd;
          if (t_wr) begin
            ref_val[t_addr[11:0]] = t_wd;
            ref_wr[t_addr[11:0]]  = 1'b1;
          end else begin
            t_rd = ref_wr[t_addr[11:0]] ? ref_val[t_addr[11:0]] : mem_default(t_addr);
          end
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_instr_read();
    test_simultaneous();
    test_starvation();
    test_data_write();
    test_reset_mid_access();
    test_read_write_both();
    test_random(2000);
    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
